// File: rtl/seg7_pkg.sv
// Shared cathode/anode encodings and scan state type for the 4-digit 7-segment driver.
// All cathode and anode patterns are active-low; segment order is {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    OFF  = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Active-low one-hot anode pattern for a digit slot.
  function automatic logic [3:0] an_onehot(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle: BCD frame inputs from the datapath and the scanned anode/cathode outputs.
// The scan driver takes the slave view; whoever produces the digits takes the master view.
interface seg7_scan_mux_if;

  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;

  modport master (
    output enable, digits, dp_in, blank_lz,
    input  an, seg, dp, digit_sel
  );

  modport slave (
    input  enable, digits, dp_in, blank_lz,
    output an, seg, dp, digit_sel
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low cathode decode; codes 10-15 render as "0".
// Zero latency, no flow control.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// 4-digit common-anode scan driver: prescaled slot rotation, per-frame snapshot, blanking, LZ suppression.
// Outputs registered, 1-cycle latency from scan state; no backpressure, inputs sampled once per frame.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_mux_if.slave io
);

  localparam int             CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_CMP = CNT_W'(BLANK_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      frm_dig_q, frm_dig_d;
  logic [3:0]       frm_dp_q, frm_dp_d;
  logic             frm_lz_q, frm_lz_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             snap;
  logic [3:0]       cur_bcd;
  logic [6:0]       cur_seg;
  logic [3:0]       lz_zero;
  logic             cur_blank;

  assign cur_bcd = frm_dig_q[{sel_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // lz_zero[i]: frame digits i..3 are all zero; digit 0 is never suppressed.
  always_comb begin
    lz_zero    = 4'b0000;
    lz_zero[3] = (frm_dig_q[15:12] == 4'd0);
    lz_zero[2] = lz_zero[3] & (frm_dig_q[11:8] == 4'd0);
    lz_zero[1] = lz_zero[2] & (frm_dig_q[7:4] == 4'd0);
    cur_blank  = frm_lz_q & lz_zero[sel_q];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    snap    = 1'b0;
    case (state_q)
      OFF: begin
        cnt_d = '0;
        sel_d = 2'd0;
        if (io.enable) begin
          state_d = SCAN;
          snap    = 1'b1;
        end
      end
      SCAN: begin
        if (!io.enable) begin
          state_d = OFF;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          sel_d = sel_q + 2'd1;
          snap  = (sel_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    frm_dig_d = frm_dig_q;
    frm_dp_d  = frm_dp_q;
    frm_lz_d  = frm_lz_q;
    if (snap) begin
      frm_dig_d = io.digits;
      frm_dp_d  = io.dp_in;
      frm_lz_d  = io.blank_lz;
    end
  end

  // A suppressed digit still drives its anode so its decimal point can light.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == SCAN && cnt_q >= BLANK_CMP) begin
      an_d  = an_onehot(sel_q);
      seg_d = cur_blank ? SEG_BLANK : cur_seg;
      dp_d  = ~frm_dp_q[sel_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      frm_dig_q <= 16'd0;
      frm_dp_q  <= 4'd0;
      frm_lz_q  <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      frm_dig_q <= frm_dig_d;
      frm_dp_q  <= frm_dp_d;
      frm_lz_q  <= frm_lz_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign io.an        = an_q;
  assign io.seg       = seg_q;
  assign io.dp        = dp_q;
  assign io.digit_sel = sel_q;

endmodule
